// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared pose encoding, sprite_state bit indices and default sprite size
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_WALK  = 2'd1,
    ST_AIR   = 2'd2
  } pose_e;

  localparam int FACE_BIT = 0;
  localparam int AIR_BIT  = 1;
  localparam int MOVE_BIT = 2;

  // Also used by the red-character instance, which shares the same sprite box.
  localparam int SPR_W_DEF = 47;
  localparam int SPR_H_DEF = 60;

endpackage

// File: rtl/sprite_anim_seq_if.sv
// rtl/sprite_anim_seq_if.sv - physics/pixel inputs and pose/ROM-address outputs of the sequencer
interface sprite_anim_seq_if;

  logic        move_left;
  logic        move_right;
  logic        airborne;
  logic        pix_valid;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic [2:0]  sprite_state;
  logic [1:0]  frame_sel;
  logic [13:0] rom_addr;
  logic        rom_addr_valid;

  modport master (
    output move_left, move_right, airborne, pix_valid, pix_x, pix_y,
    input  sprite_state, frame_sel, rom_addr, rom_addr_valid
  );

  modport slave (
    input  move_left, move_right, airborne, pix_valid, pix_x, pix_y,
    output sprite_state, frame_sel, rom_addr, rom_addr_valid
  );

endinterface

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - two-stage sprite ROM address pipeline with horizontal mirroring
module sprite_addr_gen #(
  parameter int SPR_W = 47,
  parameter int SPR_H = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_facing,
  input  logic        i_pix_valid,
  input  logic [5:0]  i_pix_x,
  input  logic [5:0]  i_pix_y,
  output logic [13:0] o_rom_addr,
  output logic        o_rom_addr_valid
);

  localparam logic [6:0] W_LIM  = 7'(SPR_W);
  localparam logic [6:0] H_LIM  = 7'(SPR_H);
  localparam logic [5:0] W_LAST = 6'(SPR_W - 1);

  logic [5:0]  r_col;
  logic [5:0]  r_row;
  logic        r_v1;
  logic [13:0] r_addr;
  logic        r_v2;
  logic        w_in_box;
  logic [5:0]  w_col;
  logic [13:0] w_addr;

  assign w_in_box = i_pix_valid && ({1'b0, i_pix_x} < W_LIM) && ({1'b0, i_pix_y} < H_LIM);
  assign w_col    = i_facing ? i_pix_x : (W_LAST - i_pix_x);
  // Out-of-box pixels present address 0 so the ROM sees a stable value.
  assign w_addr   = r_v1 ? (14'(r_row) * 14'(SPR_W) + 14'(r_col)) : 14'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_v1   <= 1'b0;
      r_addr <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_col  <= w_col;
      r_row  <= i_pix_y;
      r_v1   <= w_in_box;
      r_addr <= w_addr;
      r_v2   <= r_v1;
    end
  end

  assign o_rom_addr       = r_addr;
  assign o_rom_addr_valid = r_v2;

endmodule

// File: rtl/sprite_anim_seq.sv
// rtl/sprite_anim_seq.sv - pose FSM, animation tick divider and frame counter for one sprite
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int SPR_W           = SPR_W_DEF,
  parameter int SPR_H           = SPR_H_DEF,
  parameter int TICK_DIV        = 6000000,
  parameter int TICKS_PER_FRAME = 4,
  parameter int NUM_FRAMES      = 4
) (
  input logic              clk,
  input logic              rst,
  sprite_anim_seq_if.slave io_spr
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(TICKS_PER_FRAME - 1);
  localparam logic [1:0]        FRAME_LAST = 2'(NUM_FRAMES - 1);

  pose_e             r_pose;
  pose_e             w_pose_nxt;
  logic              r_facing;
  logic              w_facing_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [HOLD_W-1:0] r_hold;
  logic [1:0]        r_frame;
  logic              w_tick;
  logic              w_pose_chg;
  logic [2:0]        w_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pose   <= ST_STAND;
      r_facing <= 1'b1;
    end else begin
      r_pose   <= w_pose_nxt;
      r_facing <= w_facing_nxt;
    end
  end

  always_comb begin
    w_pose_nxt   = ST_STAND;
    w_facing_nxt = r_facing;
    if (io_spr.airborne) begin
      w_pose_nxt = ST_AIR;
    end else if (io_spr.move_left ^ io_spr.move_right) begin
      w_pose_nxt = ST_WALK;
    end
    if (io_spr.move_right && !io_spr.move_left) begin
      w_facing_nxt = 1'b1;
    end else if (io_spr.move_left && !io_spr.move_right) begin
      w_facing_nxt = 1'b0;
    end
  end

  assign w_pose_chg = (w_pose_nxt != r_pose);
  assign w_tick     = (r_div == DIV_LAST);

  // A pose change restarts the whole animation timebase, swallowing any coincident tick.
  always_ff @(posedge clk) begin
    if (rst || w_pose_chg) begin
      r_div   <= '0;
      r_hold  <= '0;
      r_frame <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick && (r_pose != ST_AIR)) begin
        if (r_hold == HOLD_LAST) begin
          r_hold  <= '0;
          r_frame <= (r_frame == FRAME_LAST) ? 2'd0 : r_frame + 2'd1;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state           = '0;
    w_state[FACE_BIT] = r_facing;
    w_state[AIR_BIT]  = (r_pose == ST_AIR);
    w_state[MOVE_BIT] = (r_pose == ST_WALK);
  end

  assign io_spr.sprite_state = w_state;
  assign io_spr.frame_sel    = r_frame;

  sprite_addr_gen #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_addr_gen (
    .clk             (clk),
    .rst             (rst),
    .i_facing        (r_facing),
    .i_pix_valid     (io_spr.pix_valid),
    .i_pix_x         (io_spr.pix_x),
    .i_pix_y         (io_spr.pix_y),
    .o_rom_addr      (io_spr.rom_addr),
    .o_rom_addr_valid(io_spr.rom_addr_valid)
  );

endmodule
